// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared ARM core definitions (package arm_pkg).
// Contents: EXE_CMD_* ALU command encodings, field widths, control-word bit indices
// (9-bit word: S, B, MEM_W, MEM_R, WB, then the 4-bit ALU command) and a pack helper.
package arm_pkg;

  localparam int REG_NUM_BITS = 4;
  localparam int SHIFT_W      = 12;
  localparam int IMM24_W      = 24;
  localparam int SR_W         = 4;
  localparam int EXE_CMD_W    = 4;
  localparam int CTRL_W       = 9;

  localparam int CTRL_S       = 0;
  localparam int CTRL_B       = 1;
  localparam int CTRL_MEM_W   = 2;
  localparam int CTRL_MEM_R   = 3;
  localparam int CTRL_WB      = 4;
  localparam int CTRL_CMD_LSB = 5;

  localparam logic [EXE_CMD_W-1:0] EXE_CMD_NOP = 4'b0000;
  localparam logic [EXE_CMD_W-1:0] EXE_CMD_MOV = 4'b0001;
  localparam logic [EXE_CMD_W-1:0] EXE_CMD_ADD = 4'b0010;
  localparam logic [EXE_CMD_W-1:0] EXE_CMD_ADC = 4'b0011;
  localparam logic [EXE_CMD_W-1:0] EXE_CMD_SUB = 4'b0100;
  localparam logic [EXE_CMD_W-1:0] EXE_CMD_SBC = 4'b0101;
  localparam logic [EXE_CMD_W-1:0] EXE_CMD_AND = 4'b0110;
  localparam logic [EXE_CMD_W-1:0] EXE_CMD_ORR = 4'b0111;
  localparam logic [EXE_CMD_W-1:0] EXE_CMD_EOR = 4'b1000;
  localparam logic [EXE_CMD_W-1:0] EXE_CMD_MVN = 4'b1001;

  typedef logic [CTRL_W-1:0] ctrl_word_t;

  function automatic ctrl_word_t pack_ctrl(input logic wb, input logic mem_r, input logic mem_w,
                                           input logic b, input logic s,
                                           input logic [EXE_CMD_W-1:0] cmd);
    ctrl_word_t c;
    c                                        = '0;
    c[CTRL_WB]                               = wb;
    c[CTRL_MEM_R]                            = mem_r;
    c[CTRL_MEM_W]                            = mem_w;
    c[CTRL_B]                                = b;
    c[CTRL_S]                                = s;
    c[CTRL_CMD_LSB +: EXE_CMD_W]             = cmd;
    return c;
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// ID->EXE stage bus.
// master: ID-side producer (drives *_in, freeze, flush, id_valid; observes *_out, valid_out)
// slave : the pipeline register (consumes *_in and controls, drives *_out and valid_out)
interface id_ex_pipe_reg_if #(
  parameter int BIT_NUMBER   = 32,
  parameter int REG_NUM_BITS = 4
);
  logic                    freeze, flush, id_valid;
  logic                    wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in;
  logic [3:0]              exe_cmd_in;
  logic [REG_NUM_BITS-1:0] dest_in, src1_in, src2_in;
  logic [11:0]             shift_operand_in;
  logic [23:0]             signed_imm_24_in;
  logic [BIT_NUMBER-1:0]   val_rn_in, val_rm_in, pc_in;
  logic [3:0]              sr_in;

  logic                    wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out;
  logic [3:0]              exe_cmd_out;
  logic [REG_NUM_BITS-1:0] dest_out, src1_out, src2_out;
  logic [11:0]             shift_operand_out;
  logic [23:0]             signed_imm_24_out;
  logic [BIT_NUMBER-1:0]   val_rn_out, val_rm_out, pc_out;
  logic [3:0]              sr_out;
  logic                    valid_out;

  modport master (
    output freeze, flush, id_valid, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in,
           exe_cmd_in, dest_in, src1_in, src2_in, shift_operand_in, signed_imm_24_in,
           val_rn_in, val_rm_in, pc_in, sr_in,
    input  wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out, exe_cmd_out,
           dest_out, src1_out, src2_out, shift_operand_out, signed_imm_24_out,
           val_rn_out, val_rm_out, pc_out, sr_out, valid_out
  );

  modport slave (
    input  freeze, flush, id_valid, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in,
           exe_cmd_in, dest_in, src1_in, src2_in, shift_operand_in, signed_imm_24_in,
           val_rn_in, val_rm_in, pc_in, sr_in,
    output wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out, exe_cmd_out,
           dest_out, src1_out, src2_out, shift_operand_out, signed_imm_24_out,
           val_rn_out, val_rm_out, pc_out, sr_out, valid_out
  );
endinterface

// File: rtl/id_ex_pipe_reg_sat_counter.sv
// Saturating up-counter (sticks at all-ones, never wraps).
// Ports: clk, rst (async active-low clear), inc (count enable), count (CNT_W).
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    return c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     count <= '0;
    else if (inc) count <= sat_inc(count);
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID->EXE pipeline register of the ARM core.
// Ports: clk; rst (async, active-low); bus (id_ex_pipe_reg_if.slave: ID-side *_in fields,
//   freeze, flush, id_valid in; EXE-side *_out fields and valid_out out);
//   bubble_cnt / issue_cnt (CNT_W) only when ID_EX_PERF_CNT_EN is defined.
// Priority per edge: freeze (hold everything) > flush (insert bubble) > load.
// An ID hazard bubble (id_valid=0) loads with all state-changing control bits cleared,
// so valid_out=0 always implies wb/mem_r/mem_w/b/s are 0.
module id_ex_pipe_reg #(
  parameter int BIT_NUMBER   = 32,
  parameter int REG_NUM_BITS = 4,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  id_ex_pipe_reg_if.slave  bus
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] issue_cnt
`endif
);
  import arm_pkg::*;

  logic       load_en, bubble;
  logic       ctrl_live;
  ctrl_word_t ctrl_p1;
  logic       vld_p1;

  logic                    imm_p1;
  logic [REG_NUM_BITS-1:0] dest_p1, src1_p1, src2_p1;
  logic [SHIFT_W-1:0]      shift_p1;
  logic [IMM24_W-1:0]      imm24_p1;
  logic [BIT_NUMBER-1:0]   rn_p1, rm_p1, pc_p1;
  logic [SR_W-1:0]         sr_p1;

  assign load_en   = ~bus.freeze;
  assign bubble    = bus.flush;
  assign ctrl_live = bus.id_valid;

  // ---- ID -> EXE boundary: control word and valid ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_p1 <= '0;
      vld_p1  <= 1'b0;
    end else if (load_en) begin
      if (bubble) begin
        ctrl_p1 <= '0;
        vld_p1  <= 1'b0;
      end else begin
        ctrl_p1 <= pack_ctrl(bus.wb_en_in & ctrl_live, bus.mem_r_en_in & ctrl_live,
                             bus.mem_w_en_in & ctrl_live, bus.b_in & ctrl_live,
                             bus.s_in & ctrl_live, bus.exe_cmd_in);
        vld_p1  <= bus.id_valid;
      end
    end
  end

  // ---- ID -> EXE boundary: datapath fields (loaded on flush too; don't-care then) ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      imm_p1   <= 1'b0;
      dest_p1  <= '0;
      src1_p1  <= '0;
      src2_p1  <= '0;
      shift_p1 <= '0;
      imm24_p1 <= '0;
      rn_p1    <= '0;
      rm_p1    <= '0;
      pc_p1    <= '0;
      sr_p1    <= '0;
    end else if (load_en) begin
      imm_p1   <= bus.imm_in;
      dest_p1  <= bus.dest_in;
      src1_p1  <= bus.src1_in;
      src2_p1  <= bus.src2_in;
      shift_p1 <= bus.shift_operand_in;
      imm24_p1 <= bus.signed_imm_24_in;
      rn_p1    <= bus.val_rn_in;
      rm_p1    <= bus.val_rm_in;
      pc_p1    <= bus.pc_in;
      sr_p1    <= bus.sr_in;
    end
  end

  assign bus.wb_en_out         = ctrl_p1[CTRL_WB];
  assign bus.mem_r_en_out      = ctrl_p1[CTRL_MEM_R];
  assign bus.mem_w_en_out      = ctrl_p1[CTRL_MEM_W];
  assign bus.b_out             = ctrl_p1[CTRL_B];
  assign bus.s_out             = ctrl_p1[CTRL_S];
  assign bus.exe_cmd_out       = ctrl_p1[CTRL_CMD_LSB +: EXE_CMD_W];
  assign bus.valid_out         = vld_p1;
  assign bus.imm_out           = imm_p1;
  assign bus.dest_out          = dest_p1;
  assign bus.src1_out          = src1_p1;
  assign bus.src2_out          = src2_p1;
  assign bus.shift_operand_out = shift_p1;
  assign bus.signed_imm_24_out = imm24_p1;
  assign bus.val_rn_out        = rn_p1;
  assign bus.val_rm_out        = rm_p1;
  assign bus.pc_out            = pc_p1;
  assign bus.sr_out            = sr_p1;

`ifdef ID_EX_PERF_CNT_EN
  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (load_en & bubble),
    .count (bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_issue_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (load_en & ~bubble & bus.id_valid),
    .count (issue_cnt)
  );
`endif

endmodule
